// File: rtl/bus_arb_mux_if.sv
// Bus bundle for bus_arb_mux.
// Ports carried:
//   in_data   CHANNELS*WIDTH  flattened channel words (channel i at [i*WIDTH +: WIDTH])
//   in_valid  CHANNELS        per-channel word-valid
//   in_ready  CHANNELS        per-channel accept from the arbiter
//   out_data  WIDTH           selected word
//   out_sel   SELW            index of the channel that supplied out_data
//   out_valid 1               out_data/out_sel hold a word
//   out_ready 1               downstream accept
// master: the side feeding the channels and draining the output.
// slave : the arbiter/mux itself.
interface bus_arb_mux_if #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4
);
    localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_sel;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/bus_arb_mux.sv
// N-to-1 arbitrating multiplexer with a single registered output stage.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      bus_arb_mux_if.slave (channel inputs, in_ready, registered output)
// Arbitration searches from ptr upward (wrapping) for the first valid
// channel; with ROUND_ROBIN=0 the search always starts at channel 0.
module bus_arb_mux #(
    parameter int WIDTH       = 64,
    parameter int CHANNELS    = 4,
    parameter int ROUND_ROBIN = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_arb_mux_if.slave  bus
);
    localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0]    out_data_r;
    logic [SELW-1:0]     out_sel_r;
    logic                out_valid_r;
    logic [SELW-1:0]     ptr_r;

    logic                space_s;
    logic [SELW-1:0]     start_s;
    logic [CHANNELS-1:0] grant_s;
    logic [SELW-1:0]     gsel_s;
    logic                found_s;
    logic [SELW:0]       sum_s;
    logic [CHANNELS-1:0] ready_s;
    logic                take_s;
    logic [WIDTH-1:0]    sel_data_s;
    logic [SELW-1:0]     ptr_next_s;

    // Output register can accept a word when empty or draining this cycle.
    assign space_s = !out_valid_r || bus.out_ready;

    // Search start point: rotating pointer, or fixed at channel 0.
    always_comb begin
        start_s = '0;
        if (ROUND_ROBIN != 0) begin
            start_s = ptr_r;
        end else begin
            start_s = '0;
        end
    end

    // First valid channel at or above start_s, wrapping; one-hot grant.
    always_comb begin
        grant_s = '0;
        gsel_s  = '0;
        found_s = 1'b0;
        sum_s   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum_s = {1'b0, start_s} + (SELW+1)'(k);
            if (sum_s >= (SELW+1)'(CHANNELS)) begin
                sum_s = sum_s - (SELW+1)'(CHANNELS);
            end else begin
                sum_s = sum_s;
            end
            if (!found_s && bus.in_valid[sum_s[SELW-1:0]]) begin
                found_s                    = 1'b1;
                grant_s[sum_s[SELW-1:0]]   = 1'b1;
                gsel_s                     = sum_s[SELW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Reset gates in_ready combinationally so nothing is accepted while held.
    assign ready_s      = grant_s & {CHANNELS{space_s && reset_n}};
    assign take_s       = |ready_s;
    assign bus.in_ready = ready_s;

    // AND-OR mux of the granted channel's word (grant is one-hot or zero).
    always_comb begin
        sel_data_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sel_data_s = sel_data_s | ({WIDTH{grant_s[c]}} & bus.in_data[c*WIDTH +: WIDTH]);
        end
    end

    // Pointer moves to the channel just after the winner, wrapping at the top.
    always_comb begin
        ptr_next_s = '0;
        if (gsel_s == SELW'(CHANNELS - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = gsel_s + SELW'(1);
        end
    end

    // Output register and arbitration pointer update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_r  <= '0;
            out_sel_r   <= '0;
            out_valid_r <= 1'b0;
            ptr_r       <= '0;
        end else begin
            if (take_s) begin
                out_data_r  <= sel_data_s;
                out_sel_r   <= gsel_s;
                out_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                // Drain without refill: data and index stay for observability.
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (take_s && (ROUND_ROBIN != 0)) begin
                ptr_r <= ptr_next_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;
    assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_bus_arb_mux.sv
// Self-checking bench for bus_arb_mux.
// Three instances: 4x16 round-robin (directed + random vs. reference model),
// 4x16 fixed priority, and 1x8 single channel.
module tb_bus_arb_mux;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    bus_arb_mux_if #(.WIDTH(16), .CHANNELS(4)) a_if ();
    bus_arb_mux_if #(.WIDTH(16), .CHANNELS(4)) b_if ();
    bus_arb_mux_if #(.WIDTH(8),  .CHANNELS(1)) c_if ();

    bus_arb_mux #(.WIDTH(16), .CHANNELS(4), .ROUND_ROBIN(1)) dut_a (
        .clk(clk), .reset_n(rst_a), .bus(a_if.slave));
    bus_arb_mux #(.WIDTH(16), .CHANNELS(4), .ROUND_ROBIN(0)) dut_b (
        .clk(clk), .reset_n(rst_b), .bus(b_if.slave));
    bus_arb_mux #(.WIDTH(8),  .CHANNELS(1), .ROUND_ROBIN(1)) dut_c (
        .clk(clk), .reset_n(rst_c), .bus(c_if.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model for instance A: what the output stage holds, and where
    // the next search begins.
    bit          m_valid = 1'b0;
    logic [15:0] m_data  = '0;
    int          m_sel   = 0;
    int          m_ptr   = 0;

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One clock on instance A: drive, check in_ready, advance model, check outputs.
    task automatic step_a(input logic [3:0] v, input logic [63:0] d,
                          input logic ordy, input logic rn);
        int g;
        logic [3:0] er;
        bit space;
        a_if.in_valid  = v;
        a_if.in_data   = d;
        a_if.out_ready = ordy;
        rst_a          = rn;
        #1;
        space = !m_valid || ordy;
        g = pick(v, m_ptr);
        er = 4'b0000;
        if (rn && space && g >= 0) er[g] = 1'b1;
        check_eq("a_in_ready", a_if.in_ready, er);
        if (!rn) begin
            m_valid = 1'b0; m_data = 16'h0000; m_sel = 0; m_ptr = 0;
        end else if (er != 4'b0000) begin
            m_valid = 1'b1; m_data = d[g*16 +: 16]; m_sel = g; m_ptr = (g + 1) % 4;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("a_out_valid", a_if.out_valid, m_valid);
        check_eq("a_out_data",  a_if.out_data,  m_data);
        check_eq("a_out_sel",   a_if.out_sel,   m_sel);
    endtask

    initial begin
        logic [63:0] dw;
        logic [63:0] rd;
        logic v1;
        dw = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

        rst_b = 1'b0; b_if.in_valid = 4'h0; b_if.in_data = '0; b_if.out_ready = 1'b0;
        rst_c = 1'b0; c_if.in_valid = 1'b0; c_if.in_data = '0; c_if.out_ready = 1'b0;

        // Reset, with valids asserted to show they are ignored.
        step_a(4'hF, dw, 1'b1, 1'b0);
        step_a(4'hF, dw, 1'b1, 1'b0);

        // Round-robin rotation with all channels valid.
        for (int i = 0; i < 8; i++) begin
            step_a(4'hF, dw, 1'b1, 1'b1);
            check_eq("rr_sel", a_if.out_sel, 64'(i % 4));
            check_eq("rr_valid", a_if.out_valid, 64'd1);
        end

        // Load 1111 then 2222, then stall for three cycles.
        step_a(4'hF, dw, 1'b1, 1'b1);
        step_a(4'hF, dw, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step_a(4'hF, dw, 1'b0, 1'b1);
            check_eq("bp_data", a_if.out_data, 64'h2222);
            check_eq("bp_ready", a_if.in_ready, 64'h0);
        end
        // Drain and refill in the same cycle.
        step_a(4'hF, dw, 1'b1, 1'b1);
        check_eq("nobubble_valid", a_if.out_valid, 64'd1);
        check_eq("nobubble_data", a_if.out_data, 64'h3333);

        // Single request on channel 2, then nothing.
        step_a(4'b0100, dw, 1'b1, 1'b1);
        check_eq("single_sel", a_if.out_sel, 64'd2);
        check_eq("single_data", a_if.out_data, 64'h3333);
        step_a(4'b0000, dw, 1'b1, 1'b1);
        check_eq("drain_valid", a_if.out_valid, 64'd0);
        check_eq("drain_hold", a_if.out_data, 64'h3333);

        // Reset while holding a stalled word, then restart.
        step_a(4'hF, dw, 1'b0, 1'b1);
        step_a(4'hF, dw, 1'b0, 1'b1);
        step_a(4'hF, dw, 1'b0, 1'b0);
        check_eq("rst_valid", a_if.out_valid, 64'd0);
        check_eq("rst_data", a_if.out_data, 64'd0);
        check_eq("rst_sel", a_if.out_sel, 64'd0);
        step_a(4'b1010, dw, 1'b1, 1'b1);
        check_eq("post_rst_sel", a_if.out_sel, 64'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom, $urandom};
            step_a(4'($urandom_range(0, 15)), rd,
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) != 0));
        end

        // Fixed priority: channel 0 always wins.
        b_if.in_valid = 4'hF; b_if.in_data = dw; b_if.out_ready = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("fp_in_ready", b_if.in_ready, 64'h1);
            @(posedge clk); #1;
            check_eq("fp_sel", b_if.out_sel, 64'd0);
            check_eq("fp_data", b_if.out_data, 64'h1111);
            check_eq("fp_valid", b_if.out_valid, 64'd1);
        end

        // Single channel: out_valid follows in_valid one cycle later.
        c_if.in_data = 8'hA5; c_if.out_ready = 1'b1;
        @(posedge clk); #1;
        rst_c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v1 = (i % 2 == 0);
            c_if.in_valid = v1;
            #1;
            check_eq("one_in_ready", c_if.in_ready, 64'(v1));
            @(posedge clk); #1;
            check_eq("one_valid", c_if.out_valid, 64'(v1));
            check_eq("one_sel", c_if.out_sel, 64'd0);
            check_eq("one_data", c_if.out_data, 64'hA5);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bus_arb_mux.md
BUS_ARB_MUX -- requirements
Module: bus_arb_mux

Interface
REQ-001: Parameter WIDTH, default 64, data bits per channel.
REQ-002: Parameter CHANNELS, default 4, number of input channels; legal range 1..16.
REQ-003: Parameter ROUND_ROBIN, default 1; 1 = round-robin arbitration, 0 = fixed priority with the lowest index winning.
REQ-004: Derived SELW = max(1, ceil(log2(CHANNELS))), width of all channel indices.
REQ-005: clk  input  1  single clock; all state updates on the rising edge.
REQ-006: reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-007: in_data  input  CHANNELS*WIDTH  flattened channel words; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008: in_valid  input  CHANNELS  per-channel word-valid.
REQ-009: in_ready  output  CHANNELS  per-channel accept; combinational.
REQ-010: out_data  output  WIDTH  registered selected word.
REQ-011: out_sel  output  SELW  registered index of the channel that supplied out_data.
REQ-012: out_valid  output  1  registered; out_data and out_sel hold a word.
REQ-013: out_ready  input  1  downstream accept.

Function
REQ-014: The block SHALL contain one output register (out_data, out_sel, out_valid) and one round-robin pointer ptr (SELW bits, values 0..CHANNELS-1).
REQ-015: space = !out_valid || out_ready; the output register can load in the current cycle only when space is 1.
REQ-016: The grant SHALL be one-hot or zero, computed combinationally from in_valid and ptr. It selects the first asserted in_valid found at or above ptr, wrapping from index CHANNELS-1 to 0. When ROUND_ROBIN=0 the search SHALL start at index 0.
REQ-017: in_ready[i] SHALL equal grant[i] && space; at most one in_ready bit is high in any cycle.
REQ-018: in_ready SHALL NOT depend on in_data. in_ready[i] SHALL be 0 while in_valid[i] is 0.
REQ-019: A transfer on channel g occurs when in_valid[g] && in_ready[g]. On the next edge out_data becomes that channel's word, out_sel becomes g and out_valid becomes 1.
REQ-020: Latency from an input transfer to out_valid SHALL be exactly 1 cycle. Sustained throughput SHALL be 1 word per cycle while out_ready stays 1.
REQ-021: When out_valid && out_ready and no input transfer occurs, out_valid SHALL become 0 on the next edge. out_data and out_sel SHALL keep their last values.
REQ-022: When out_valid && !out_ready, out_data, out_sel and out_valid SHALL stay unchanged, and every in_ready bit SHALL be 0.
REQ-023: A simultaneous output drain and input transfer SHALL replace the word in the same cycle with no bubble.
REQ-024: ROUND_ROBIN=1: after a transfer from channel g, ptr SHALL become (g+1) mod CHANNELS. Without a transfer, ptr SHALL hold. Any continuously requesting channel SHALL be granted within CHANNELS transfers.
REQ-025: ROUND_ROBIN=0: ptr SHALL stay 0.
REQ-026: CHANNELS=1: channel 0 is always the granted channel when valid; ptr and out_sel SHALL stay 0.
REQ-027: An upstream channel SHALL hold in_data and in_valid until its transfer. The block SHALL NOT require this for correctness of other channels.

Reset
REQ-028: While reset_n=0 at an edge, the block SHALL set out_valid=0, out_data=0, out_sel=0 and ptr=0.
REQ-029: While reset_n is low, in_ready SHALL be all 0 regardless of in_valid.
REQ-030: Reset during a held word (out_valid=1, out_ready=0) SHALL discard the word without any output transfer.
REQ-031: The first grant after reset SHALL go to the lowest-indexed valid channel.

Verification
REQ-032: WIDTH=16, CHANNELS=4, RR. in_data ch0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444; all in_valid=1; out_ready=1 for 8 cycles -> out_sel sequence is 0,1,2,3,0,1,2,3, out_data matches each channel, out_valid stays 1 after the first cycle.
REQ-033: Backpressure: out_ready=0 with out_valid=1 (out_data=16'h2222) for 3 cycles -> output stable, in_ready=4'b0000; out_ready=1 -> next word loads in the same cycle as the drain with no bubble.
REQ-034: Only in_valid[2] high, then dropped after its transfer -> out_sel=2, out_data=16'h3333 for 1 cycle, then out_valid=0 with data held.
REQ-035: ROUND_ROBIN=0, all channels valid for 4 cycles -> out_sel stays 0 every cycle; ch3 is never granted.
REQ-036: reset_n=0 while a word is held with out_ready=0 -> next edge gives out_valid=0, out_data=0, out_sel=0. After release with in_valid=4'b1010, the first out_sel=1.
REQ-037: CHANNELS=1, WIDTH=8: in_data=8'hA5, in_valid toggling each cycle, out_ready=1 -> out_valid follows in_valid delayed by 1 cycle, out_sel=0.
